pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_3000, fetch address loaded by reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 redirect  in  1  next-PC unit selected a non-sequential target this cycle.
REQ-005 npc_i  in  32  redirect target (branch/jump/jr result).
REQ-006 imem_req_valid  out  1  instruction-memory request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_addr  out  32  request address, equals pc_o.
REQ-009 imem_rsp_valid  in  1  read data returned (one per accepted request, in order).
REQ-010 imem_rsp_data  in  32  returned instruction word.
REQ-011 inst_valid  out  1  instruction presented to decode.
REQ-012 inst_ready  in  1  decode consumes instruction.
REQ-013 inst_o  out  32  instruction word.
REQ-014 inst_pc  out  32  address of inst_o (PC for PC+4 / link generation).
REQ-015 pc_o  out  32  current fetch PC.
REQ-016 fetch_fault  out  1  misaligned redirect target held (see Configuration).

Function
REQ-017 States SHALL be REQ, WAIT, FULL, KILL, FAULT; at most one memory request outstanding.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc_o; handshake (valid&ready) -> WAIT.
REQ-019 WAIT: imem_rsp_valid -> capture inst_o=imem_rsp_data, inst_pc=pc_o, go FULL.
REQ-020 FULL: inst_valid=1; inst_ready -> pc_o<=pc_o+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go REQ.
REQ-021 KILL: request outstanding for a squashed address; next imem_rsp_valid discarded, go REQ.
REQ-022 Redirect SHALL load pc_o<=npc_i next cycle in every state, overriding pc_o+4.
REQ-023 Redirect in REQ without handshake -> stay REQ; with handshake same cycle -> KILL.
REQ-024 Redirect in WAIT without response -> KILL; with response same cycle -> response dropped, go REQ.
REQ-025 Redirect in FULL -> held instruction dropped unless inst_ready same cycle (then delivered); go REQ.
REQ-026 Redirect in KILL -> stay KILL (pending response still discarded).
REQ-027 imem_rsp_valid outside WAIT/KILL SHALL be ignored.
REQ-028 inst_valid, once high, SHALL hold inst_o/inst_pc stable until inst_ready or redirect.
REQ-029 imem_req_valid SHALL not drop before handshake except on redirect or rst.
REQ-030 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, FULL with zero-wait memory).

Reset
REQ-031 rst high at a clock edge: state=REQ, pc_o=RESET_PC, inst_valid=0, inst_o=0, inst_pc=0, fetch_fault=0, imem_req_valid=1 the cycle after rst deasserts.
REQ-032 rst SHALL override redirect and any in-flight handshake; an outstanding response after reset is ignored per REQ-027.

Configuration
REQ-033 Macro FETCH_ALIGN_CHK_EN defined: redirect with npc_i[1:0]!=0 -> state FAULT, pc_o=npc_i, fetch_fault=1, no requests, inst_valid=0; FAULT exits only on aligned redirect (-> REQ) or rst.
REQ-034 Macro FETCH_ALIGN_CHK_EN undefined: pc_o loads {npc_i[31:2],2'b00}; FAULT state absent; fetch_fault tied 0.

Verification
REQ-035 rst 1 cycle, ready=1, rsp one cycle after request, inst_ready=1 -> addresses 0x3000,0x3004,0x3008 each 3 cycles apart; inst_pc matches.
REQ-036 inst_ready=0 for 5 cycles in FULL with inst 0x2408_0005 -> inst_valid and inst_o stable, no new request, advances to 0x3004 after ready.
REQ-037 Redirect npc_i=0x3040 while WAIT for 0x3008 -> response 0xDEADBEEF never reaches inst_o; next request 0x3040.
REQ-038 Redirect npc_i=0x3100 same cycle as FULL handshake of 0x300C -> 0x300C delivered once, next request 0x3100.
REQ-039 With FETCH_ALIGN_CHK_EN: redirect 0x3102 -> fetch_fault=1, no requests; redirect 0x3200 -> fault clears, request 0x3200. Without: redirect 0x3102 -> request 0x3100.
REQ-040 rst asserted in WAIT, response arrives next cycle -> response ignored, first request 0x3000.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry holding slot toward decode.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHK_EN.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] npc_i,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_o,
   output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHK_EN
   typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_KILL, S_FAULT} state_t;
`else
   typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_KILL} state_t;
`endif

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        capture;
   logic        req_hs;

   assign req_hs = (state == S_REQ) && imem_req_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;
      case (state)
         S_REQ: begin
            // A request accepted in a redirect cycle still owes us a response to discard.
            if (req_hs)
               state_nxt = redirect ? S_KILL : S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect) begin
                  state_nxt = S_REQ;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_FULL;
               end
            end else if (redirect) begin
               state_nxt = S_KILL;
            end
         end
         S_FULL: begin
            if (redirect) begin
               state_nxt = S_REQ;
            end else if (inst_ready) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = S_REQ;
            end
         end
         S_KILL: begin
            // The squashed response retires the outstanding request even if another redirect lands now.
            if (imem_rsp_valid)
               state_nxt = S_REQ;
         end
`ifdef FETCH_ALIGN_CHK_EN
         S_FAULT: state_nxt = S_FAULT;
`endif
         default: state_nxt = S_REQ;
      endcase

      if (redirect) begin
`ifdef FETCH_ALIGN_CHK_EN
         if (npc_i[1:0] != 2'b00) begin
            pc_nxt    = npc_i;
            state_nxt = S_FAULT;
         end else begin
            pc_nxt = npc_i;
            if (state == S_FAULT)
               state_nxt = S_REQ;
         end
`else
         pc_nxt = npc_i & 32'hFFFF_FFFC;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         inst_q    <= 32'd0;
         inst_pc_q <= 32'd0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (capture) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc;
         end
      end
   end

   assign imem_req_valid = (state == S_REQ);
   assign imem_addr      = pc;
   assign pc_o           = pc;
   assign inst_valid     = (state == S_FULL);
   assign inst_o         = inst_q;
   assign inst_pc        = inst_pc_q;
`ifdef FETCH_ALIGN_CHK_EN
   assign fetch_fault    = (state == S_FAULT);
`else
   assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed per-cycle vector table, then random traffic against a
// transaction-level model (outstanding/squash/holding flags rather than an FSM).
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] npc_i = 32'd0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic [31:0] pc_o;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;

   pc_fetch dut (
      .clk(clk), .rst(rst), .redirect(redirect), .npc_i(npc_i),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .inst_pc(inst_pc),
      .pc_o(pc_o), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        redirect;
      logic [31:0] npc;
      logic        ready;
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        iready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
      logic        e_fault;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic rd, input logic [31:0] npc,
                               input logic rdy, input logic rv, input logic [31:0] rdat,
                               input logic ir, input logic e_req, input logic [31:0] e_addr,
                               input logic e_iv, input logic [31:0] e_inst,
                               input logic [31:0] e_ipc, input logic e_fault);
      vec_t v;
      v.rst = r; v.redirect = rd; v.npc = npc; v.ready = rdy; v.rsp_v = rv; v.rsp_d = rdat;
      v.iready = ir; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
      v.e_ipc = e_ipc; v.e_fault = e_fault;
      tbl.push_back(v);
   endfunction

   task automatic drive(input logic r, input logic rd, input logic [31:0] npc, input logic rdy,
                        input logic rv, input logic [31:0] rdat, input logic ir);
      rst = r; redirect = rd; npc_i = npc; imem_req_ready = rdy;
      imem_rsp_valid = rv; imem_rsp_data = rdat; inst_ready = ir;
   endtask

   // Reference model: one request in flight, a squash flag, and a one-deep holding slot.
   logic [31:0] m_pc;
   logic        m_out;
   logic        m_squash;
   logic        m_hold;
   logic [31:0] m_inst;
   logic [31:0] m_ipc;

   function automatic logic m_req_valid();
      return !m_out && !m_hold;
   endfunction

   task automatic model_step(input logic r, input logic rd, input logic [31:0] npc,
                             input logic rdy, input logic rv, input logic [31:0] rdat,
                             input logic ir);
      logic        hs;
      logic [31:0] newpc;
      if (r) begin
         m_pc = 32'h0000_3000; m_out = 0; m_squash = 0; m_hold = 0; m_inst = 0; m_ipc = 0;
         return;
      end
      hs    = m_req_valid() && rdy;
      newpc = m_pc;
      if (m_hold && ir) begin
         m_hold = 0;
         newpc  = m_pc + 32'd4;
      end
      if (m_hold && rd) m_hold = 0;
      if (rd) newpc = {npc[31:2], 2'b00};
      if (m_out && rv) begin
         if (!m_squash && !rd) begin
            m_hold = 1; m_inst = rdat; m_ipc = m_pc;
         end
         m_out = 0; m_squash = 0;
      end else if (m_out && rd) begin
         m_squash = 1;
      end
      if (hs) begin
         m_out = 1; m_squash = rd;
      end
      m_pc = newpc;
   endtask

   initial begin
      // rst, redir, npc, ready, rsp_v, rsp_d, inst_ready | req, addr, iv, inst, inst_pc, fault
      add(1, 0, 0,            0, 0, 0,            0, 1, 32'h3000, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3000, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h24080005, 0, 0, 32'h3000, 1, 32'h24080005, 32'h3000, 0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0,         1, 1, 32'h0BAD0BAD, 0, 0, 32'h3000, 1, 32'h24080005, 32'h3000, 0);
      add(0, 0, 0,            0, 0, 0,            1, 1, 32'h3004, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3004, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h11111111, 0, 0, 32'h3004, 1, 32'h11111111, 32'h3004, 0);
      add(0, 0, 0,            0, 0, 0,            1, 1, 32'h3008, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3008, 0, 0,            0,        0);
      add(0, 1, 32'h3040,     0, 0, 0,            0, 0, 32'h3040, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'hDEADBEEF, 0, 1, 32'h3040, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3040, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h22222222, 0, 0, 32'h3040, 1, 32'h22222222, 32'h3040, 0);
      add(0, 1, 32'h3100,     0, 0, 0,            1, 1, 32'h3100, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3100, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h33333333, 0, 0, 32'h3100, 1, 32'h33333333, 32'h3100, 0);
      add(0, 0, 0,            0, 0, 0,            1, 1, 32'h3104, 0, 0,            0,        0);
`ifdef FETCH_ALIGN_CHK_EN
      add(0, 1, 32'h3102,     0, 0, 0,            0, 0, 32'h3102, 0, 0,            0,        1);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3102, 0, 0,            0,        1);
`else
      add(0, 1, 32'h3102,     0, 0, 0,            0, 1, 32'h3100, 0, 0,            0,        0);
`endif
      add(0, 1, 32'h3200,     0, 0, 0,            0, 1, 32'h3200, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3200, 0, 0,            0,        0);
      add(1, 0, 0,            0, 0, 0,            0, 1, 32'h3000, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'hDEAD0000, 0, 1, 32'h3000, 0, 0,            0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'h3000, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h44444444, 0, 0, 32'h3000, 1, 32'h44444444, 32'h3000, 0);
      add(0, 1, 32'hFFFFFFFC, 0, 0, 0,            1, 1, 32'hFFFFFFFC, 0, 0,          0,        0);
      add(0, 0, 0,            1, 0, 0,            0, 0, 32'hFFFFFFFC, 0, 0,          0,        0);
      add(0, 0, 0,            0, 1, 32'h55555555, 0, 0, 32'hFFFFFFFC, 1, 32'h55555555, 32'hFFFFFFFC, 0);
      add(0, 0, 0,            0, 0, 0,            1, 1, 32'h0,    0, 0,            0,        0);
      add(0, 1, 32'h4000,     1, 0, 0,            0, 0, 32'h4000, 0, 0,            0,        0);
      add(0, 1, 32'h5000,     0, 0, 0,            0, 0, 32'h5000, 0, 0,            0,        0);
      add(0, 0, 0,            0, 1, 32'h66666666, 0, 1, 32'h5000, 0, 0,            0,        0);
      add(1, 1, 32'h7000,     1, 0, 0,            0, 1, 32'h3000, 0, 0,            0,        0);

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].redirect, tbl[i].npc, tbl[i].ready, tbl[i].rsp_v,
               tbl[i].rsp_d, tbl[i].iready);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_req});
         chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d pc_o", i), pc_o, tbl[i].e_addr);
         chk($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
         chk($sformatf("vec%0d fetch_fault", i), {31'd0, fetch_fault}, {31'd0, tbl[i].e_fault});
         if (tbl[i].e_iv || tbl[i].rst) begin
            chk($sformatf("vec%0d inst_o", i), inst_o, tbl[i].e_inst);
            chk($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
         end
      end

      for (int c = 0; c < 3000; c++) begin
         logic        r, rd, rdy, rv, ir;
         logic [31:0] npc, rdat;
         r    = (c == 0) || ($urandom_range(0, 99) < 2);
         rd   = ($urandom_range(0, 99) < 12);
         npc  = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
         npc[1:0] = 2'b00;
`endif
         if ($urandom_range(0, 3) == 0) npc = 32'hFFFF_FFFC;
         rdy  = $urandom_range(0, 1);
         rv   = $urandom_range(0, 1);
         rdat = $urandom;
         ir   = $urandom_range(0, 1);
         @(negedge clk);
         drive(r, rd, npc, rdy, rv, rdat, ir);
         model_step(r, rd, npc, rdy, rv, rdat, ir);
         @(posedge clk);
         #1;
         chk("rnd req_valid", {31'd0, imem_req_valid}, {31'd0, m_req_valid()});
         chk("rnd pc_o", pc_o, m_pc);
         chk("rnd imem_addr", imem_addr, m_pc);
         chk("rnd inst_valid", {31'd0, inst_valid}, {31'd0, m_hold});
         chk("rnd fetch_fault", {31'd0, fetch_fault}, 32'd0);
         if (m_hold) begin
            chk("rnd inst_o", inst_o, m_inst);
            chk("rnd inst_pc", inst_pc, m_ipc);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
